ntt_bram_stream_io: RTL and testbench

//  Stream front/back end for the 18x16K coefficient BRAM of the NTT core.

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/ntt_out_fifo2.sv | 51 +++++
 rtl/ntt_bram_stream_io.sv | 134 +++++++++++++
 tb/tb_ntt_bram_stream_io.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared defaults, FSM encoding and the bit-reversal helper for the NTT BRAM stream front/back end.
package ntt_pkg;

    localparam int NTT_DW   = 18;
    localparam int NTT_AW   = 14;
    localparam int NTT_LOGN = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2,
        DONE   = 2'd3
    } ntt_state_e;

    // Bit i of k moves to bit logn-1-i; bits at or above logn come out zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int logn);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < logn) begin
                r[5'(logn - 1 - i)] = k[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_out_fifo2.sv
// Two-entry output FIFO; push and pop may happen in the same cycle, head is registered.
module ntt_out_fifo2 #(
    parameter int DW = 18
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [0:1];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ntt_bram_stream_io.sv
// Stream load/unload engine for the NTT coefficient BRAM: writes N words (optionally bit-reversed)
// and reads them back in natural order through a 2-entry skid FIFO that hides the BRAM read latency.
module ntt_bram_stream_io
    import ntt_pkg::*;
#(
    parameter int DW     = NTT_DW,
    parameter int AW     = NTT_AW,
    parameter int LOGN   = NTT_LOGN,
    parameter bit BITREV = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_load,
    input  logic          start_unload,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          bram_wr_en,
    output logic [AW-1:0] bram_wr_addr,
    output logic [DW-1:0] bram_wr_din,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [DW-1:0] bram_rd_dout,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam int            CW      = LOGN + 1;
    localparam logic [CW-1:0] N_WORDS = {1'b1, {LOGN{1'b0}}};
    localparam logic [CW-1:0] LAST    = N_WORDS - 1'b1;

    // Handshakes: a word moves on in_* (or out_*) only in a cycle where valid and ready are both high;
    // ready never depends on valid, and out_data/out_valid hold steady while out_ready is low.

    ntt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          inflight_q, inflight_d;

    logic          fifo_pop;
    logic [1:0]    fifo_count;
    logic [2:0]    occ;

    ntt_out_fifo2 #(.DW(DW)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .din_i   (bram_rd_dout),
        .pop_i   (fifo_pop),
        .dout_o  (out_data),
        .valid_o (out_valid),
        .count_o (fifo_count)
    );

    assign fifo_pop = out_valid && out_ready;
    // Slots committed after this edge: queued words minus the one leaving now, plus the read in flight.
    assign occ      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        inflight_d   = 1'b0;
        in_ready     = 1'b0;
        bram_wr_en   = 1'b0;
        bram_wr_addr = '0;

        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (start_unload) begin
                    // Word 0 is read in the start cycle so the first output appears two cycles later.
                    state_d    = UNLOAD;
                    rd_addr_d  = '0;
                    inflight_d = 1'b1;
                    cnt_d      = {{(CW-1){1'b0}}, 1'b1};
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bram_wr_en   = 1'b1;
                    bram_wr_addr = BITREV ? AW'(bitrev(32'(cnt_q), LOGN)) : AW'(cnt_q);
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            UNLOAD: begin
                if ((cnt_q != N_WORDS) && (occ < 3'd2)) begin
                    rd_addr_d  = AW'(cnt_q);
                    inflight_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
                if ((cnt_q == N_WORDS) && !inflight_q && (fifo_count == 2'd1) && fifo_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
        end
    end

    assign bram_wr_din  = in_data;
    assign bram_rd_addr = rd_addr_d;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ntt_bram_stream_io.sv
// Directed bench for ntt_bram_stream_io at LOGN=3: bit-reversed and natural loads, unloads with
// and without backpressure, start arbitration and mid-unload reset, against hand-computed values.
module tb_ntt_bram_stream_io;

    localparam int DW  = 18;
    localparam int AW  = 14;
    localparam int NW  = 8;
    localparam int TMO = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start_load = 1'b0, start_unload = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, wr_en, busy, done;
    logic [DW-1:0] out_data, wr_din, rd_dout;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    dbg_state;

    logic          n_start_load = 1'b0, n_in_valid = 1'b0;
    logic [DW-1:0] n_in_data = '0;
    logic          n_in_ready, n_out_valid, n_wr_en, n_busy, n_done;
    logic [DW-1:0] n_out_data, n_wr_din;
    logic [DW-1:0] n_rd_dout;
    logic [AW-1:0] n_wr_addr, n_rd_addr;
    logic [1:0]    n_dbg_state;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int            br_tbl [NW] = '{0, 4, 2, 6, 1, 5, 3, 7};
    bit            gap_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    ntt_bram_stream_io #(.DW(DW), .AW(AW), .LOGN(3), .BITREV(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_unload(start_unload),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bram_wr_en(wr_en), .bram_wr_addr(wr_addr), .bram_wr_din(wr_din),
        .bram_rd_addr(rd_addr), .bram_rd_dout(rd_dout),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    ntt_bram_stream_io #(.DW(DW), .AW(AW), .LOGN(3), .BITREV(1'b0)) u_nat (
        .clk(clk), .rst(rst), .start_load(n_start_load), .start_unload(1'b0),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(1'b0), .out_data(n_out_data),
        .bram_wr_en(n_wr_en), .bram_wr_addr(n_wr_addr), .bram_wr_din(n_wr_din),
        .bram_rd_addr(n_rd_addr), .bram_rd_dout(n_rd_dout),
        .busy(n_busy), .done(n_done), .dbg_state(n_dbg_state)
    );

    assign n_rd_dout = '0;

    // BRAM model: synchronous write, registered-address read (data one cycle after the address).
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_din;
        rd_dout <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_wr_en"},     wr_en,     0);
        check({tag, "_wr_addr"},   wr_addr,   0);
        check({tag, "_rd_addr"},   rd_addr,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    task automatic fill_expected();
        exp_q.delete();
        for (int a = 0; a < NW; a++) exp_q.push_back(DW'(br_tbl[a]));
    endtask

    // Load 0..7 with both starts raised together; a stray start_unload arrives mid-load.
    task automatic load_bitrev();
        @(posedge clk); #1 start_load = 1'b1; start_unload = 1'b1;
        @(posedge clk); #1 start_load = 1'b0; start_unload = 1'b0;
        for (int k = 0; k < NW; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(k);
            start_unload = (k == 3);
            @(negedge clk);
            check("load_state", dbg_state, 1);
            check("load_in_ready", in_ready, 1);
            check("load_wr_en", wr_en, 1);
            check("load_wr_addr", wr_addr, br_tbl[k]);
            check("load_wr_din", wr_din, k);
            @(posedge clk); #1;
        end
        start_unload = 1'b0;
        @(negedge clk);
        check("load_done", done, 1);
        check("load_done_busy", busy, 1);
        check("load_done_wr_en", wr_en, 0);
        check("load_done_in_ready", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("load_after_done", done, 0);
        check("load_after_busy", busy, 0);
        check("load_back_idle", dbg_state, 0);
    endtask

    task automatic run_unload(input bit toggle, input int abort_after, output int n_out,
                              output int n_done, output int first_cyc, output int done_cyc);
        int            cyc;
        bit            stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        n_out = 0; n_done = 0; first_cyc = -1; done_cyc = -1;
        stalled = 1'b0; held = '0; cyc = 0;
        @(posedge clk); #1 start_unload = 1'b1; out_ready = 1'b1;
        while (cyc < TMO) begin
            if (cyc > 0) begin
                @(posedge clk); #1 start_unload = 1'b0;
                out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            end
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held);
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
                n_out++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (abort_after > 0 && n_out == abort_after) break;
            if (done) break;
            cyc++;
        end
        if (cyc == TMO) check("unload_timeout", 0, 1);
    endtask

    task automatic load_nat_gaps();
        int k;
        int cyc;
        @(posedge clk); #1 n_start_load = 1'b1;
        @(posedge clk); #1 n_start_load = 1'b0;
        k = 0; cyc = 0;
        while (k < NW && cyc < TMO) begin
            n_in_valid = gap_pat[cyc % 5];
            n_in_data  = DW'(256 + k);
            @(negedge clk);
            if (n_in_valid) begin
                check("nat_wr_en", n_wr_en, 1);
                check("nat_wr_addr", n_wr_addr, k);
                check("nat_wr_din", n_wr_din, 256 + k);
                k++;
            end else begin
                check("nat_gap_wr_en", n_wr_en, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_in_valid = 1'b0;
        check("nat_word_count", k, NW);
        @(negedge clk);
        check("nat_done", n_done, 1);
        check("nat_done_wr_en", n_wr_en, 0);
    endtask

    initial begin
        int n_out, n_done, first_cyc, done_cyc;

        // Clock/reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_state", dbg_state, 0);

        load_bitrev();

        fill_expected();
        run_unload(1'b0, 0, n_out, n_done, first_cyc, done_cyc);
        check("full_words", n_out, NW);
        check("full_done_count", n_done, 1);
        check("full_first_valid_cycle", first_cyc, 2);
        check("full_done_cycle", done_cyc, 10);
        check("full_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("full_post_done", done, 0);
        check("full_post_busy", busy, 0);

        fill_expected();
        run_unload(1'b1, 0, n_out, n_done, first_cyc, done_cyc);
        check("toggle_words", n_out, NW);
        check("toggle_done_count", n_done, 1);
        check("toggle_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1 out_ready = 1'b0;

        load_nat_gaps();

        fill_expected();
        run_unload(1'b0, 3, n_out, n_done, first_cyc, done_cyc);
        check("abort_words_before_rst", n_out, 3);
        check("abort_no_done_before", n_done, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("abort");
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        fill_expected();
        run_unload(1'b0, 0, n_out, n_done, first_cyc, done_cyc);
        check("reload_words", n_out, NW);
        check("reload_done_count", n_done, 1);
        check("reload_queue_empty", exp_q.size(), 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
